uart_rx_fifo: RTL and testbench



---
 rtl/uart_rx_fifo.sv | 182 ++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 serial receiver with receive FIFO and sticky error flags
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   rx         serial input (asynchronous, idle high)
//   rd_data    FIFO head byte, 8'h00 while rd_valid is low
//   rd_valid   FIFO not empty
//   rd_ready   pop the head when rd_valid && rd_ready
//   level      FIFO occupancy
//   frame_err  sticky: stop bit sampled low
//   overrun    sticky: good byte arrived with the FIFO full and no pop
//   clr_err    one-cycle pulse clearing both sticky flags
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 234,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx,
    output logic [7:0]                    rd_data,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          frame_err,
    output logic                          overrun,
    input  logic                          clr_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [AW:0]   PTR_ONE   = (AW+1)'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_IDLE
    } state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [2:0]    bit_idx, bit_idx_d;
    logic [7:0]    shreg, shreg_d;
    logic          rx_meta, rx_s;
    logic          push, set_fe, set_ov;

    logic [AW:0]   wr_ptr, rd_ptr;
    logic [7:0]    mem [FIFO_DEPTH];
    logic          full, pop;

    // Two-flop synchronizer; reset high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            bit_idx <= bit_idx_d;
            shreg   <= shreg_d;
        end
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        bit_idx_d = bit_idx;
        shreg_d   = shreg;
        push      = 1'b0;
        set_fe    = 1'b0;
        set_ov    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end
            ST_START: begin
                if (cnt == HALF_LAST) begin
                    if (rx_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d   = ST_DATA;
                        cnt_d     = '0;
                        bit_idx_d = '0;
                    end
                end else begin
                    cnt_d = cnt + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (cnt == BIT_LAST) begin
                    // LSB first: each bit enters at the top and walks down.
                    shreg_d   = {rx_s, shreg[7:1]};
                    cnt_d     = '0;
                    bit_idx_d = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    cnt_d = cnt + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (cnt == BIT_LAST) begin
                    if (rx_s) begin
                        // A pop on the same edge frees the slot being written.
                        if (!full || pop) begin
                            push = 1'b1;
                        end else begin
                            set_ov = 1'b1;
                        end
                        state_d = ST_IDLE;
                    end else begin
                        set_fe  = 1'b1;
                        state_d = ST_WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt + CNT_ONE;
                end
            end
            ST_WAIT_IDLE: begin
                // Hold off during a break so a long low line cannot retrigger.
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FIFO: pointers carry one extra wrap bit to tell full from empty.
    assign rd_valid = (wr_ptr != rd_ptr);
    assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign pop      = rd_valid && rd_ready;
    assign level    = wr_ptr - rd_ptr;
    assign rd_data  = rd_valid ? mem[rd_ptr[AW-1:0]] : 8'h00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= shreg;
    end

    // Sticky flags: a new event wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (set_fe)       frame_err <= 1'b1;
            else if (clr_err) frame_err <= 1'b0;
            if (set_ov)       overrun   <= 1'b1;
            else if (clr_err) overrun   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;
    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       rd_ready = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [2:0] level;
    logic       frame_err;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .level(level), .frame_err(frame_err), .overrun(overrun), .clr_err(clr_err)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Ideal 8N1 frame; rd_ready is raised for exactly one edge at pop_cycle (-1: never).
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int pop_cycle);
        logic [9:0] bits;
        bits = {stop_bit, d, 1'b0};
        for (int c = 0; c < 10 * CPB; c++) begin
            rx       = bits[c / CPB];
            rd_ready = (c == pop_cycle);
            @(posedge clk);
            #1;
        end
        rd_ready = 1'b0;
        rx       = 1'b1;
    endtask

    task automatic pop_byte(output logic [7:0] b, output logic v);
        @(negedge clk);
        b        = rd_data;
        v        = rd_valid;
        rd_ready = 1'b1;
        @(posedge clk);
        #1;
        rd_ready = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        @(negedge clk);
        checks++; if (rd_valid !== 1'b0)  begin errors++; $display("FAIL rst_valid got %0b exp 0", rd_valid); end
        checks++; if (rd_data !== 8'h00)  begin errors++; $display("FAIL rst_data got %0h exp 00", rd_data); end
        checks++; if (level !== 3'd0)     begin errors++; $display("FAIL rst_level got %0d exp 0", level); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rst_fe got %0b exp 0", frame_err); end
        checks++; if (overrun !== 1'b0)   begin errors++; $display("FAIL rst_ov got %0b exp 0", overrun); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(4);
    endtask

    task automatic test_single();
        logic [7:0] b;
        logic v;
        send_frame(8'hA5, 1'b1, -1);
        tick(2);
        @(negedge clk);
        checks++; if (rd_valid !== 1'b1)  begin errors++; $display("FAIL single_valid got %0b exp 1", rd_valid); end
        checks++; if (rd_data !== 8'hA5)  begin errors++; $display("FAIL single_data got %0h exp a5", rd_data); end
        checks++; if (level !== 3'd1)     begin errors++; $display("FAIL single_level got %0d exp 1", level); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL single_fe got %0b exp 0", frame_err); end
        checks++; if (overrun !== 1'b0)   begin errors++; $display("FAIL single_ov got %0b exp 0", overrun); end
        pop_byte(b, v);
        @(negedge clk);
        checks++; if (rd_valid !== 1'b0)  begin errors++; $display("FAIL single_pop_valid got %0b exp 0", rd_valid); end
        checks++; if (rd_data !== 8'h00)  begin errors++; $display("FAIL single_pop_data got %0h exp 00", rd_data); end
        tick(2);
    endtask

    task automatic test_glitch();
        logic [7:0] b;
        logic v;
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(12);
        @(negedge clk);
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL glitch_level got %0d exp 0", level); end
        @(posedge clk);
        #1;
        // Receiver must already be idle again for this frame to land correctly.
        send_frame(8'h5A, 1'b1, -1);
        tick(2);
        @(negedge clk);
        checks++; if (level !== 3'd1)    begin errors++; $display("FAIL glitch_next_level got %0d exp 1", level); end
        checks++; if (rd_data !== 8'h5A) begin errors++; $display("FAIL glitch_next_data got %0h exp 5a", rd_data); end
        pop_byte(b, v);
        tick(2);
    endtask

    task automatic test_frame_err();
        logic [7:0] b;
        logic v;
        send_frame(8'h3C, 1'b0, -1);
        rx = 1'b0;
        tick(40);
        @(negedge clk);
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL fe_set got %0b exp 1", frame_err); end
        checks++; if (level !== 3'd0)     begin errors++; $display("FAIL fe_level got %0d exp 0", level); end
        @(posedge clk);
        #1;
        rx = 1'b1;
        tick(4);
        send_frame(8'h11, 1'b1, -1);
        tick(2);
        @(negedge clk);
        checks++; if (level !== 3'd1)    begin errors++; $display("FAIL fe_next_level got %0d exp 1", level); end
        checks++; if (rd_data !== 8'h11) begin errors++; $display("FAIL fe_next_data got %0h exp 11", rd_data); end
        pop_byte(b, v);
        pulse_clr();
        @(negedge clk);
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL fe_clr got %0b exp 0", frame_err); end
        checks++; if (overrun !== 1'b0)   begin errors++; $display("FAIL fe_ov got %0b exp 0", overrun); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_overrun();
        logic [7:0] b;
        logic v;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, -1);
        tick(2);
        @(negedge clk);
        checks++; if (level !== 3'd4)     begin errors++; $display("FAIL ovr_level got %0d exp 4", level); end
        checks++; if (overrun !== 1'b1)   begin errors++; $display("FAIL ovr_flag got %0b exp 1", overrun); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ovr_fe got %0b exp 0", frame_err); end
        @(posedge clk);
        #1;
        for (int i = 1; i <= 4; i++) begin
            pop_byte(b, v);
            checks++; if (v !== 1'b1 || b !== 8'(i)) begin errors++; $display("FAIL ovr_pop%0d got %0b/%0h exp 1/%0h", i, v, b, i); end
        end
        @(negedge clk);
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL ovr_drained got %0b exp 0", rd_valid); end
        @(posedge clk);
        #1;
        pulse_clr();
        @(negedge clk);
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clr got %0b exp 0", overrun); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_full_pop();
        logic [7:0] b;
        logic v;
        for (int i = 1; i <= 4; i++) send_frame(8'h60 + 8'(i), 1'b1, -1);
        // Stop-bit sample edge is the 155th edge after the start bit falls.
        send_frame(8'h65, 1'b1, 154);
        tick(2);
        @(negedge clk);
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL fullpop_ov got %0b exp 0", overrun); end
        checks++; if (level !== 3'd4)   begin errors++; $display("FAIL fullpop_level got %0d exp 4", level); end
        @(posedge clk);
        #1;
        for (int i = 2; i <= 5; i++) begin
            pop_byte(b, v);
            checks++; if (v !== 1'b1 || b !== 8'h60 + 8'(i)) begin errors++; $display("FAIL fullpop_pop%0d got %0b/%0h exp 1/%0h", i, v, b, 8'h60 + 8'(i)); end
        end
        tick(2);
    endtask

    task automatic test_random();
        logic [7:0] q[$];
        logic [7:0] d, b, exp_b;
        logic v, mov;
        int n;
        mov = 1'b0;
        for (int it = 0; it < 24; it++) begin
            d = 8'($urandom);
            send_frame(d, 1'b1, -1);
            if (q.size() < DEPTH) q.push_back(d);
            else mov = 1'b1;
            n = $urandom_range(0, 3);
            if (n > 0) tick(n);
            @(negedge clk);
            checks++; if (level !== 3'(q.size())) begin errors++; $display("FAIL rnd_level it%0d got %0d exp %0d", it, level, q.size()); end
            checks++; if (overrun !== mov)         begin errors++; $display("FAIL rnd_ov it%0d got %0b exp %0b", it, overrun, mov); end
            @(posedge clk);
            #1;
            n = $urandom_range(0, q.size());
            for (int k = 0; k < n; k++) begin
                exp_b = q.pop_front();
                pop_byte(b, v);
                checks++; if (v !== 1'b1 || b !== exp_b) begin errors++; $display("FAIL rnd_pop it%0d got %0b/%0h exp 1/%0h", it, v, b, exp_b); end
            end
        end
        while (q.size() > 0) begin
            exp_b = q.pop_front();
            pop_byte(b, v);
            checks++; if (v !== 1'b1 || b !== exp_b) begin errors++; $display("FAIL rnd_drain got %0b/%0h exp 1/%0h", v, b, exp_b); end
        end
        pulse_clr();
        tick(2);
    endtask

    task automatic test_reset_mid();
        logic [9:0] bits;
        logic [7:0] b;
        logic v;
        send_frame(8'h21, 1'b1, -1);
        send_frame(8'h22, 1'b1, -1);
        @(negedge clk);
        checks++; if (level !== 3'd2) begin errors++; $display("FAIL rmid_pre_level got %0d exp 2", level); end
        @(posedge clk);
        #1;
        bits = {1'b1, 8'hF3, 1'b0};
        for (int c = 0; c < 10 * CPB; c++) begin
            rx    = bits[c / CPB];
            rst_n = (c != 5 * CPB);
            if (c == 5 * CPB) begin
                #1;
                checks++; if (rd_valid !== 1'b0)  begin errors++; $display("FAIL rmid_valid got %0b exp 0", rd_valid); end
                checks++; if (rd_data !== 8'h00)  begin errors++; $display("FAIL rmid_data got %0h exp 00", rd_data); end
                checks++; if (level !== 3'd0)     begin errors++; $display("FAIL rmid_level got %0d exp 0", level); end
                checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rmid_fe got %0b exp 0", frame_err); end
            end
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        rx    = 1'b1;
        tick(20);
        @(negedge clk);
        checks++; if (level !== 3'd0)     begin errors++; $display("FAIL rmid_post_level got %0d exp 0", level); end
        checks++; if (overrun !== 1'b0)   begin errors++; $display("FAIL rmid_post_ov got %0b exp 0", overrun); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rmid_post_fe got %0b exp 0", frame_err); end
        @(posedge clk);
        #1;
        send_frame(8'h7E, 1'b1, -1);
        tick(2);
        @(negedge clk);
        checks++; if (level !== 3'd1)    begin errors++; $display("FAIL rmid_new_level got %0d exp 1", level); end
        checks++; if (rd_data !== 8'h7E) begin errors++; $display("FAIL rmid_new_data got %0h exp 7e", rd_data); end
        pop_byte(b, v);
        tick(2);
    endtask

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_full_pop();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
